// File: rtl/fft_collect_pkg.sv
// Shared types, sizes and index helpers for the FFT output collector.
// A frame is BEATS vectors of LANES words; word 2k is re and word 2k+1 is im.
package fft_collect_pkg;

    localparam int WORD_W    = 32;
    localparam int LANES     = 16;
    localparam int BEATS     = 4;
    localparam int PAIRS     = LANES / 2;
    localparam int FRAME_PTS = PAIRS * BEATS;
    localparam int IDX_W     = $clog2(FRAME_PTS);
    localparam int BEAT_W    = $clog2(BEATS);
    localparam int LANE_W    = $clog2(PAIRS);

    typedef struct packed {
        logic [WORD_W-1:0] re;
        logic [WORD_W-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_CAPT = 2'd1,
        W_DROP = 2'd2
    } wr_state_t;

    // Sample k lives in beat k/PAIRS at complex lane k%PAIRS.
    function automatic logic [LANE_W-1:0] lane_of(input logic [IDX_W-1:0] idx);
        return LANE_W'(idx % IDX_W'(PAIRS));
    endfunction

    function automatic logic [BEAT_W-1:0] beat_of(input logic [IDX_W-1:0] idx);
        return BEAT_W'(idx / IDX_W'(PAIRS));
    endfunction

endpackage

// File: rtl/fft_out_collector_if.sv
// Sample stream port of the collector: one complex sample per valid/ready handshake.
interface fft_out_collector_if;
    import fft_collect_pkg::*;

    logic              m_valid;
    logic              m_ready;
    logic [WORD_W-1:0] m_re;
    logic [WORD_W-1:0] m_im;
    logic [IDX_W-1:0]  m_idx;
    logic              m_last;

    modport master (output m_valid, m_re, m_im, m_idx, m_last, input m_ready);
    modport slave  (input m_valid, m_re, m_im, m_idx, m_last, output m_ready);

endinterface

// File: rtl/fft_frame_bank.sv
// One frame of storage: whole-beat writes, single complex sample read per cycle.
// rd_idx is the index wanted on the NEXT cycle; rd_data is its registered read.
module fft_frame_bank
    import fft_collect_pkg::*;
(
    input  logic                         clk,
    input  logic                         wr_en,
    input  logic [BEAT_W-1:0]            wr_beat,
    input  logic [LANES-1:0][WORD_W-1:0] wr_data,
    input  logic [IDX_W-1:0]             rd_idx,
    output cplx_t                        rd_data
);

    cplx_t             lane_rd [PAIRS];
    logic [LANE_W-1:0] sel_q;

    // One narrow memory per complex lane so a full beat lands in a single cycle.
    generate
        for (genvar gi = 0; gi < PAIRS; gi++) begin : g_lane
            cplx_t mem [BEATS];
            cplx_t rd_q;

            always_ff @(posedge clk) begin
                if (wr_en) begin
                    mem[wr_beat] <= cplx_t'{re: wr_data[2*gi], im: wr_data[2*gi+1]};
                end
                rd_q <= mem[beat_of(rd_idx)];
            end

            assign lane_rd[gi] = rd_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        sel_q <= lane_of(rd_idx);
    end

    assign rd_data = lane_rd[sel_q];

endmodule

// File: rtl/fft_out_collector.sv
// Captures transform output frames into a ping-pong buffer and replays them sample by sample.
// Define FFT_COLLECT_STATS_EN to add saturating frames_done / frames_dropped counters.
module fft_out_collector
    import fft_collect_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         next_out,
    input  logic [LANES-1:0][WORD_W-1:0] y_in,
    fft_out_collector_if.master          m,
    output logic                         overrun,
    input  logic                         overrun_clr
`ifdef FFT_COLLECT_STATS_EN
    ,
    output logic [15:0]                  frames_done,
    output logic [15:0]                  frames_dropped
`endif
);

    wr_state_t         state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [1:0]        full_q, full_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              overrun_q, overrun_d;

    logic              last_beat, frame_end, accept, drop_start;
    logic              valid, last_pt, handshake;
    logic [1:0]        wr_en;
    cplx_t             bank_rd [2];

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        full_d     = full_q;
        idx_d      = idx_q;
        overrun_d  = overrun_q;
        drop_start = 1'b0;

        last_beat = (beat_q == BEAT_W'(BEATS - 1));
        frame_end = (state_q != W_IDLE) && last_beat;
        accept    = next_out && ((state_q == W_IDLE) || frame_end);

        if (state_q != W_IDLE) begin
            beat_d = last_beat ? '0 : beat_q + 1'b1;
        end
        if (frame_end) begin
            state_d = W_IDLE;
            if (state_q == W_CAPT) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end
        end
        // A start on the final beat looks at the bank the write pointer is moving to.
        if (accept) begin
            beat_d = '0;
            if (full_q[wr_bank_d]) begin
                state_d    = W_DROP;
                drop_start = 1'b1;
            end else begin
                state_d = W_CAPT;
            end
        end

        valid     = full_q[rd_bank_q];
        last_pt   = (idx_q == IDX_W'(FRAME_PTS - 1));
        handshake = valid && m.m_ready;
        if (handshake) begin
            if (last_pt) begin
                idx_d             = '0;
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        if (drop_start) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= W_IDLE;
            beat_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            full_q    <= '0;
            idx_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
        end
    end

    assign wr_en = {(state_q == W_CAPT) && wr_bank_q, (state_q == W_CAPT) && !wr_bank_q};

    // Both banks track idx_d so the bank that becomes readable already holds sample 0.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            fft_frame_bank u_bank (
                .clk     (clk),
                .wr_en   (wr_en[gi]),
                .wr_beat (beat_q),
                .wr_data (y_in),
                .rd_idx  (idx_d),
                .rd_data (bank_rd[gi])
            );
        end
    endgenerate

    assign m.m_valid = valid;
    assign m.m_re    = valid ? bank_rd[rd_bank_q].re : '0;
    assign m.m_im    = valid ? bank_rd[rd_bank_q].im : '0;
    assign m.m_idx   = idx_q;
    assign m.m_last  = valid && last_pt;
    assign overrun   = overrun_q;

`ifdef FFT_COLLECT_STATS_EN
    logic [15:0] done_q, done_d, dropped_q, dropped_d;

    always_comb begin
        done_d    = done_q;
        dropped_d = dropped_q;
        if (handshake && last_pt && (done_q != 16'hFFFF)) begin
            done_d = done_q + 16'd1;
        end
        if (drop_start && (dropped_q != 16'hFFFF)) begin
            dropped_d = dropped_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q    <= '0;
            dropped_q <= '0;
        end else begin
            done_q    <= done_d;
            dropped_q <= dropped_d;
        end
    end

    assign frames_done    = done_q;
    assign frames_dropped = dropped_q;
`endif

endmodule

// File: tb/tb_fft_out_collector.sv
// Directed + randomized bench for fft_out_collector with a frame-level scoreboard.
module tb_fft_out_collector;
    import fft_collect_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic next_out = 1'b0;
    logic overrun;
    logic overrun_clr = 1'b0;
    logic [LANES-1:0][WORD_W-1:0] y_in = '0;
`ifdef FFT_COLLECT_STATS_EN
    logic [15:0] frames_done, frames_dropped;
`endif

    fft_out_collector_if bus ();

    fft_out_collector dut (
        .clk         (clk),
        .reset       (reset),
        .next_out    (next_out),
        .y_in        (y_in),
        .m           (bus),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
`ifdef FFT_COLLECT_STATS_EN
        , .frames_done    (frames_done)
        , .frames_dropped (frames_dropped)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WORD_W-1:0] re;
        logic [WORD_W-1:0] im;
        int                idx;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;
    int   cap_cnt  = 0;
    int   cons_cnt = 0;
    int   drop_cnt = 0;
    bit   exp_overrun = 1'b0;
    bit   rand_ready  = 1'b0;
    bit   pat_mode    = 1'b0;
    logic [LANES-1:0][WORD_W-1:0] frame [BEATS];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) bus.m_ready = 1'($urandom_range(0, 1));
    endtask

    // A new frame is dropped when two complete frames are already buffered
    // (a frame whose last beat is being sent this cycle counts as buffered).
    function automatic bit decide();
        bit d;
        d = (cap_cnt - cons_cnt) >= 2;
        if (d) begin
            exp_overrun = 1'b1;
            drop_cnt++;
        end
        return d;
    endfunction

    task automatic build_frame(input int mode);
        for (int b = 0; b < BEATS; b++)
            for (int w = 0; w < LANES; w++)
                frame[b][w] = (mode != 0) ? $urandom : {16'h0000, 8'(b), 8'(w)};
    endtask

    task automatic commit(input bit drop);
        exp_t e;
        if (!drop) begin
            for (int k = 0; k < FRAME_PTS; k++) begin
                e.re  = frame[k / PAIRS][2 * (k % PAIRS)];
                e.im  = frame[k / PAIRS][2 * (k % PAIRS) + 1];
                e.idx = k;
                exp_q.push_back(e);
            end
            cap_cnt++;
        end
    endtask

    task automatic send_frames(input int n, input int mode, input bit b2b, input bit chk_lat);
        bit drop;
        tick();
        next_out = 1'b1;
        drop = decide();
        for (int i = 0; i < n; i++) begin
            build_frame(mode);
            for (int b = 0; b < BEATS; b++) begin
                tick();
                next_out = 1'b0;
                y_in = frame[b];
                if (b == BEATS - 1) begin
                    if (chk_lat) chk("valid_before_last_beat", bus.m_valid, 0);
                    commit(drop);
                    if (b2b && i < n - 1) begin
                        next_out = 1'b1;
                        drop = decide();
                    end
                end
            end
            if (!b2b && i < n - 1) begin
                tick();
                y_in = {LANES{$urandom}};
                next_out = 1'b1;
                drop = decide();
            end
        end
        tick();
        next_out = 1'b0;
        y_in = {LANES{$urandom}};
        if (chk_lat) chk("valid_latency", bus.m_valid, 1);
    endtask

    task automatic drain(input string tag, input bit toggle);
        int c = 0;
        while (exp_q.size() != 0 && c < 3000) begin
            tick();
            if (toggle) bus.m_ready = !bus.m_ready;
            c++;
        end
        chk({tag, "_drained"}, exp_q.size(), 0);
        repeat (3) tick();
        chk({tag, "_idle"}, bus.m_valid, 0);
    endtask

    // Scoreboard: every handshake pops one expected sample; stalls must hold the outputs.
    initial begin
        exp_t              e;
        bit                stall = 1'b0;
        logic [WORD_W-1:0] h_re, h_im;
        logic [IDX_W-1:0]  h_idx;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall = 1'b0;
            end else begin
                if (stall && bus.m_valid) begin
                    chk("hold_re", bus.m_re, h_re);
                    chk("hold_im", bus.m_im, h_im);
                    chk("hold_idx", bus.m_idx, h_idx);
                end
                if (bus.m_valid && bus.m_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_sample", bus.m_valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("re[%0d]", e.idx), bus.m_re, e.re);
                        chk($sformatf("im[%0d]", e.idx), bus.m_im, e.im);
                        chk($sformatf("idx[%0d]", e.idx), bus.m_idx, e.idx);
                        chk($sformatf("last[%0d]", e.idx), bus.m_last, e.idx == FRAME_PTS - 1);
                        if (pat_mode && e.idx == 9) begin
                            chk("s9_re", bus.m_re, 32'h0000_0102);
                            chk("s9_im", bus.m_im, 32'h0000_0103);
                        end
                        if (e.idx == FRAME_PTS - 1) cons_cnt++;
                    end
                end
                stall = bus.m_valid && !bus.m_ready;
                h_re  = bus.m_re;
                h_im  = bus.m_im;
                h_idx = bus.m_idx;
            end
        end
    end

    initial begin
        bus.m_ready = 1'b0;
        repeat (3) tick();
        chk("rst_valid", bus.m_valid, 0);
        chk("rst_last", bus.m_last, 0);
        chk("rst_idx", bus.m_idx, 0);
        chk("rst_re", bus.m_re, 0);
        chk("rst_im", bus.m_im, 0);
        chk("rst_overrun", overrun, 0);
        reset = 1'b0;

        // Single patterned frame, sink always ready
        bus.m_ready = 1'b1;
        pat_mode = 1'b1;
        send_frames(1, 0, 1'b0, 1'b1);
        drain("single", 1'b0);
        pat_mode = 1'b0;

        // Three frames back-to-back with the sink stalled: third is dropped
        bus.m_ready = 1'b0;
        send_frames(3, 1, 1'b1, 1'b0);
        repeat (5) tick();
        chk("overrun_set", overrun, exp_overrun);
        chk("valid_while_stalled", bus.m_valid, 1);
        bus.m_ready = 1'b1;
        drain("three", 1'b0);
`ifdef FFT_COLLECT_STATS_EN
        chk("frames_done", frames_done, cons_cnt);
        chk("frames_dropped", frames_dropped, drop_cnt);
`endif
        tick();
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        exp_overrun = 1'b0;
        chk("overrun_clr", overrun, exp_overrun);
`ifdef FFT_COLLECT_STATS_EN
        chk("frames_done_after_clr", frames_done, cons_cnt);
        chk("frames_dropped_after_clr", frames_dropped, drop_cnt);
`endif

        // next_out on the final beat, sink ready
        send_frames(2, 1, 1'b1, 1'b0);
        drain("b2b", 1'b0);

        // Ready toggling every cycle
        bus.m_ready = 1'b0;
        send_frames(1, 1, 1'b0, 1'b0);
        drain("toggle", 1'b1);

        // Random ready with mixed spacing
        rand_ready = 1'b1;
        send_frames(4, 1, 1'b0, 1'b0);
        send_frames(3, 1, 1'b1, 1'b0);
        drain("rand", 1'b0);
        rand_ready = 1'b0;
        chk("overrun_rand", overrun, exp_overrun);

        // Fill both banks and set overrun, then reset during beat 2 of another frame
        bus.m_ready = 1'b0;
        send_frames(3, 1, 1'b1, 1'b0);
        chk("pre_reset_overrun", overrun, exp_overrun);
        tick();
        next_out = 1'b1;
        tick();
        next_out = 1'b0;
        y_in = {LANES{$urandom}};
        tick();
        y_in = {LANES{$urandom}};
        tick();
        y_in = {LANES{$urandom}};
        reset = 1'b1;
        #1;
        chk("midreset_valid", bus.m_valid, 0);
        chk("midreset_overrun", overrun, 0);
        exp_q.delete();
        cap_cnt = 0;
        cons_cnt = 0;
        drop_cnt = 0;
        exp_overrun = 1'b0;
        tick();
        reset = 1'b0;
        bus.m_ready = 1'b1;
        send_frames(1, 1, 1'b0, 1'b1);
        drain("post_reset", 1'b0);
        chk("post_reset_overrun", overrun, exp_overrun);
`ifdef FFT_COLLECT_STATS_EN
        chk("post_reset_done", frames_done, cons_cnt);
        chk("post_reset_dropped", frames_dropped, drop_cnt);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
